// File: rtl/pyc_pkt_rr_arb_if.sv
// Bundle of requester-side and downstream-side ready/valid signals for the
// packet round-robin arbiter. The slave modport is the arbiter's view.
interface pyc_pkt_rr_arb_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SEL_W = $clog2(N <= 1 ? 2 : N);

  logic [N-1:0]            in_valid;
  logic [N-1:0]            in_ready;
  logic [N-1:0][WIDTH-1:0] in_data;
  logic [N-1:0]            in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_last;
  logic [SEL_W-1:0]        out_sel;
  logic                    busy;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel, busy
  );
endinterface

// File: rtl/pyc_pkt_rr_arb.sv
// Packet-aware round-robin arbiter: grant locks to one requester for a whole
// packet, and the head of rotation may send up to QUANTUM packets per turn.
module pyc_pkt_rr_arb #(
  parameter int WIDTH   = 32,
  parameter int N       = 4,
  parameter int QUANTUM = 1
) (
  input logic               clk,
  input logic               rst_n,
  pyc_pkt_rr_arb_if.slave   bus
);
  localparam int SEL_W = $clog2(N <= 1 ? 2 : N);
  localparam int CNT_W = $clog2(QUANTUM + 1);

  logic             locked, locked_nxt;
  logic [SEL_W-1:0] owner, owner_nxt;
  logic [SEL_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0] pkt_cnt, pkt_cnt_nxt;
  logic [SEL_W-1:0] sel;
  logic             vld, ovld, fire;

  // Selection: owner while locked, otherwise first valid scanning from rr_ptr.
  // The scan runs backwards so the lowest offset from rr_ptr wins.
  always_comb begin
    sel = '0;
    vld = 1'b0;
    if (locked) begin
      sel = owner;
      vld = bus.in_valid[owner];
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (bus.in_valid[(int'(rr_ptr) + k) % N]) begin
          sel = SEL_W'((int'(rr_ptr) + k) % N);
          vld = 1'b1;
        end
      end
    end
  end

  assign ovld = rst_n & vld;
  assign fire = ovld & bus.out_ready;

  always_comb begin
    bus.out_valid = ovld;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    if (ovld) begin
      bus.out_data = bus.in_data[sel];
      bus.out_last = bus.in_last[sel];
    end
    bus.out_sel  = rst_n ? sel : '0;
    bus.busy     = rst_n & locked;
    bus.in_ready = '0;
    if (fire) bus.in_ready[sel] = 1'b1;
  end

  always_comb begin
    locked_nxt  = locked;
    owner_nxt   = owner;
    rr_ptr_nxt  = rr_ptr;
    pkt_cnt_nxt = pkt_cnt;
    if (fire) begin
      if (!bus.in_last[sel]) begin
        locked_nxt = 1'b1;
        owner_nxt  = sel;
      end else begin
        locked_nxt = 1'b0;
        // Head of rotation keeps its turn until its quantum is spent.
        if (sel == rr_ptr && pkt_cnt < CNT_W'(QUANTUM - 1)) begin
          pkt_cnt_nxt = pkt_cnt + 1'b1;
        end else begin
          rr_ptr_nxt  = (sel == SEL_W'(N - 1)) ? '0 : sel + 1'b1;
          pkt_cnt_nxt = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked  <= 1'b0;
      owner   <= '0;
      rr_ptr  <= '0;
      pkt_cnt <= '0;
    end else begin
      locked  <= locked_nxt;
      owner   <= owner_nxt;
      rr_ptr  <= rr_ptr_nxt;
      pkt_cnt <= pkt_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_pyc_pkt_rr_arb.sv
// Directed bench: N=4/QUANTUM=1 instance for rotation, locking, stalls and
// reset; N=2/QUANTUM=2 instance for the packet quantum.
module tb_pyc_pkt_rr_arb;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  pyc_pkt_rr_arb_if #(.WIDTH(32), .N(4)) if4 ();
  pyc_pkt_rr_arb_if #(.WIDTH(32), .N(2)) if2 ();

  pyc_pkt_rr_arb #(.WIDTH(32), .N(4), .QUANTUM(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave)
  );
  pyc_pkt_rr_arb #(.WIDTH(32), .N(2), .QUANTUM(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int q_seq[8];
    int q_tail[3];
    q_seq  = '{0, 0, 1, 1, 0, 0, 1, 1};
    q_tail = '{0, 0, 1};

    rst_n         = 1'b0;
    if4.in_valid  = 4'b1111;
    if4.in_last   = 4'b1111;
    if4.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) if4.in_data[i] = 32'h100 + i;
    if2.in_valid  = 2'b00;
    if2.in_last   = 2'b11;
    if2.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) if2.in_data[i] = 32'h200 + i;

    // reset holds everything quiet even with all requesters valid
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_out_valid", if4.out_valid, 0);
      chk("rst_in_ready", if4.in_ready, 0);
      chk("rst_busy", if4.busy, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_sel", if4.out_sel, 0);
    chk("first_valid", if4.out_valid, 1);

    // plain rotation, single-beat packets: 0,1,2,3,0 -> rr_ptr ends at 1
    for (int k = 0; k < 5; k++) begin
      chk("rot_sel", if4.out_sel, k % 4);
      chk("rot_ready", if4.in_ready, 32'(1 << (k % 4)));
      chk("rot_data", if4.out_data, 32'h100 + (k % 4));
      tick();
    end

    // 3-beat packet from input 1 with inputs 0 and 2 competing
    if4.in_valid   = 4'b0111;
    if4.in_last    = 4'b0101;
    if4.in_data[1] = 32'h1B1;
    #1;
    chk("lock_b1_sel", if4.out_sel, 1);
    chk("lock_b1_busy", if4.busy, 0);
    tick();
    if4.in_data[1] = 32'h1B2;
    #1;
    chk("lock_b2_sel", if4.out_sel, 1);
    chk("lock_b2_busy", if4.busy, 1);
    if4.out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("bp_data", if4.out_data, 32'h1B2);
      chk("bp_ready", if4.in_ready, 0);
      chk("bp_valid", if4.out_valid, 1);
      tick();
    end
    if4.out_ready = 1'b1;
    if4.in_valid  = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_valid", if4.out_valid, 0);
      chk("stall_busy", if4.busy, 1);
      chk("stall_ready", if4.in_ready, 0);
      tick();
    end
    if4.in_valid = 4'b0111;
    #1;
    chk("resume_sel", if4.out_sel, 1);
    chk("resume_data", if4.out_data, 32'h1B2);
    chk("resume_ready", if4.in_ready, 32'b0010);
    tick();
    if4.in_data[1] = 32'h1B3;
    if4.in_last    = 4'b0111;
    #1;
    chk("lock_b3_sel", if4.out_sel, 1);
    chk("lock_b3_last", if4.out_last, 1);
    chk("lock_b3_busy", if4.busy, 1);
    tick();
    chk("after_pkt_busy", if4.busy, 0);
    chk("after_pkt_sel", if4.out_sel, 2);
    chk("after_pkt_data", if4.out_data, 32'h102);
    tick();

    // wrap: consume from input 3, pointer returns to 0
    if4.in_valid = 4'b1001;
    if4.in_last  = 4'b1111;
    #1;
    chk("wrap_pre_sel", if4.out_sel, 3);
    tick();
    chk("wrap_sel", if4.out_sel, 0);

    // reset in the middle of a 4-beat packet from input 3
    if4.in_valid   = 4'b1000;
    if4.in_last    = 4'b0000;
    if4.in_data[3] = 32'h3C1;
    #1;
    chk("mid_b1_sel", if4.out_sel, 3);
    tick();
    if4.in_data[3] = 32'h3C2;
    #1;
    chk("mid_b2_busy", if4.busy, 1);
    tick();
    chk("mid_locked_busy", if4.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", if4.busy, 0);
    chk("mid_rst_valid", if4.out_valid, 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    if4.in_valid = 4'b1001;
    if4.in_last  = 4'b1111;
    #1;
    chk("post_rst_sel", if4.out_sel, 0);
    chk("post_rst_busy", if4.busy, 0);
    tick();
    if4.in_valid = 4'b0000;

    // quantum of 2 packets per turn
    if2.in_valid = 2'b11;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("quant_sel", if2.out_sel, q_seq[k]);
      chk("quant_data", if2.out_data, 32'h200 + q_seq[k]);
      tick();
    end
    chk("quant_cnt1_sel", if2.out_sel, 0);
    tick();
    if2.in_valid = 2'b10;
    #1;
    chk("quant_other_sel", if2.out_sel, 1);
    tick();
    if2.in_valid = 2'b11;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("quant_reset_sel", if2.out_sel, q_tail[k]);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
